// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, default bit timing, data
// width and the parity helper. Used by both the transmit and receive ends
// so that they agree on frame format.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 434;  // 50 MHz / 115200 baud
  localparam int DATA_W           = 8;
  localparam int IDX_W            = $clog2(DATA_W);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_t;

  // Even parity: XOR of all data bits.
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-stream handshake plus serial-line outputs of the UART transmitter.
// master = byte producer, slave = the transmitter.
interface uart_tx_if;
  import uart_pkg::*;

  logic [DATA_W-1:0] byte_in;
  logic              valid;
  logic              ready;
  logic              busy;
  logic              tx;

  modport master (output byte_in, valid, input ready, busy, tx);
  modport slave  (input byte_in, valid, output ready, busy, tx);

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter. Counts 0..CLKS_PER_BIT-1 while enabled and pulses
// bit_done for one cycle on the last clock of each bit period, reloading
// to 0 at the same edge. clear restarts the period (used on accept).
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic en,
  output logic bit_done
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Free-run within a bit period, reload to 0 at each boundary.
  always_ff @(posedge clk) begin
    if (!reset_n || clear)
      cnt <= '0;
    else if (en)
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  assign bit_done = en && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 8N1 frames, LSB first, tx idle high.
// Optional feature: define UART_TX_PARITY_EN to insert an even-parity bit
// between data bit 7 and the stop bit (frame becomes 11 bit periods).
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic     clk,
  input  logic     reset_n,
  uart_tx_if.slave bus
);

  uart_state_t       state;
  logic [DATA_W-1:0] shreg;
  logic [IDX_W-1:0]  bit_idx;
  logic              tx_q;
  logic              ready_q;
  logic              accept;
  logic              run;
  logic              bit_done;

  assign accept = bus.valid && ready_q;
  assign run    = (state != IDLE);

  uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk      (clk),
    .reset_n  (reset_n),
    .clear    (accept),
    .en       (run),
    .bit_done (bit_done)
  );

  // Frame sequencer. tx and ready are registered so each changes on the
  // same edge as the state. The shift register rotates rather than shifts,
  // so the full byte is still present when parity is needed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      shreg   <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg   <= bus.byte_in;
            bit_idx <= '0;
            tx_q    <= 1'b0;
            ready_q <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (bit_done) begin
            tx_q  <= shreg[0];
            state <= DATA;
          end
        end
        DATA: begin
          if (bit_done) begin
            shreg   <= {shreg[0], shreg[DATA_W-1:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == IDX_W'(DATA_W - 1)) begin
`ifdef UART_TX_PARITY_EN
              tx_q  <= even_parity(shreg);
              state <= PARITY;
`else
              tx_q  <= 1'b1;
              state <= STOP;
`endif
            end else begin
              tx_q <= shreg[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            tx_q  <= 1'b1;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (bit_done) begin
            ready_q <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.tx    = tx_q;
  assign bus.ready = ready_q;
  assign bus.busy  = ~ready_q;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, SHALL set the clk cycles per serial bit (50 MHz / 115200); legal range 2..65535.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  SHALL be a synchronous, active-low reset.
REQ-004 byte_in  input  8  SHALL carry the byte to transmit, sampled only on an accepting edge.
REQ-005 valid  input  1  SHALL indicate that byte_in holds a byte for transmission.
REQ-006 ready  output  1  SHALL indicate the block can accept a byte this cycle.
REQ-007 tx  output  1  SHALL be the serial line output, idle high.
REQ-008 busy  output  1  SHALL be high while a frame is on the line.

Function
REQ-009 A byte SHALL be accepted on a rising edge where valid=1 and ready=1; byte_in is latched into an internal shift register on that edge.
REQ-010 Once the byte is accepted, ready SHALL be 0 until the frame completes.
REQ-011 The state machine SHALL have these states and transitions:
- IDLE -> START on accept.
- START -> DATA after CLKS_PER_BIT cycles.
- DATA -> PARITY after 8 bits (when REQ-023 applies), otherwise DATA -> STOP.
- PARITY -> STOP after CLKS_PER_BIT cycles.
- STOP -> IDLE after CLKS_PER_BIT cycles.
REQ-012 tx SHALL be driven from a register, with this latency and timing:
- the start bit (0) appears on the first cycle after the accepting edge;
- every bit is held for exactly CLKS_PER_BIT cycles.
REQ-013 Data bits SHALL be sent LSB first, bit 0 through bit 7.
REQ-014 The stop bit SHALL be one bit period of 1.
REQ-015 ready SHALL be 1 in IDLE and 0 in all other states.
REQ-016 busy SHALL be the complement of ready.
REQ-017 Back-to-back frames: after the last stop-bit cycle, the FSM returns to IDLE with ready=1.
- If valid is held high, the next start bit begins one cycle later.
- The gap of tx=1 between frames is therefore exactly 1 cycle beyond the stop bit.
REQ-018 Changes on byte_in or valid while busy SHALL have no effect on the frame in progress.
REQ-019 The bit-period counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL reload to 0 at every bit boundary.
REQ-020 The bit index counter SHALL be 3 bits wide and SHALL wrap at 7 without overflow side effects.

Reset
REQ-021 When reset_n=0 at a rising edge, the block SHALL enter this state on the next cycle:
- state=IDLE, tx=1, ready=1, busy=0;
- both counters=0 and the shift register=0.
REQ-022 Reset asserted mid-frame SHALL abort the frame immediately, with tx high on the next cycle and no partial stop bit; reset takes priority over an accept in the same cycle.

Configuration
REQ-023 With macro UART_TX_PARITY_EN defined, the block SHALL insert one even-parity bit (XOR of the 8 data bits) between bit 7 and the stop bit.
- Frame length is then 11*CLKS_PER_BIT cycles.
- The parity value is computed from the latched byte.
REQ-024 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent; frame length is 10*CLKS_PER_BIT cycles.

Structure
REQ-025 A shared package uart_pkg SHALL hold:
- the FSM state typedef (IDLE, START, DATA, PARITY, STOP);
- the default CLKS_PER_BIT constant;
- the data width constant (8).
REQ-026 The bit-period counter SHALL be a sub-module uart_baud_gen, which emits a one-cycle bit_done pulse and is cleared by uart_tx on accept.
REQ-027 The receive-side block SHALL import the same uart_pkg constants, so that both ends agree on frame format.

Verification (CLKS_PER_BIT=4)
REQ-028 The bench SHALL drive reset_n=0 for 2 cycles, then release it, and check:
- tx=1, ready=1 and busy=0 immediately after the reset edge;
- the outputs are stable for 10 idle cycles.
REQ-029 The bench SHALL send valid=1 with byte_in=0xA5 for one cycle and check:
- tx = 0,1,0,1,0,0,1,0,1,1 (start, data LSB first, stop), each bit 4 cycles;
- ready returns 1 after 40 cycles.
REQ-030 The bench SHALL hold valid=1 across two bytes, 0x00 then 0xFF, and check:
- the second start bit begins exactly 41 cycles after the first start bit;
- no byte is dropped or duplicated.
REQ-031 The bench SHALL toggle byte_in and valid randomly during the frame of 0x3C and check that the serial output still equals 0x3C.
REQ-032 The bench SHALL assert reset_n=0 during data bit 3 of 0xA5 and check:
- tx=1 and ready=1 on the next cycle;
- a following 0x5A frame is transmitted correctly.
REQ-033 With UART_TX_PARITY_EN defined, the bench SHALL check:
- 0xA5 produces parity bit 0 and a 44-cycle frame;
- 0x01 produces parity bit 1.
